// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, addresses the combinational instruction
// memory, and registers the fetched word into the IF/ID stage register.
// Redirects (branch, jump) resolved in ID take effect on the next edge and
// leave exactly one bubble. Fetch stops once the PC passes the program end.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          PROG_WORDS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] PROG_WORDS_W = 32'(PROG_WORDS);

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc4_reg, pc4_next;
  logic        valid_reg, valid_next;
  logic        halted_reg, halted_next;
  logic [15:0] count_reg, count_next;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        past_end;
  logic        redirect;

  // Derived datapath values: sequential PC, jump target from the upper PC
  // bits of the instruction in ID, and the end-of-program test on word index.
  always_comb begin
    pc_plus4    = pc_reg + 32'd4;
    jump_target = {pc4_reg[31:28], jump_index, 2'b00};
    past_end    = ((pc_reg >> 2) >= PROG_WORDS_W);
    redirect    = branch_taken | jump;
  end

  // Next-state and next-register logic; everything holds unless a case
  // below says otherwise. Branch beats jump, and both beat stall.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    pc4_next   = pc4_reg;
    valid_next = valid_reg;
    count_next = count_reg;

    case (state_reg)
      START: begin
        state_next = RUN;
        instr_next = 32'h0000_0000;
        pc4_next   = 32'h0000_0000;
        valid_next = 1'b0;
      end

      RUN, HALT: begin
        if (redirect) begin
          // Redirect also revives a halted sequencer: the last fetched
          // instruction can still resolve in ID after fetch stopped.
          state_next = RUN;
          pc_next    = branch_taken ? branch_target : jump_target;
          instr_next = 32'h0000_0000;
          pc4_next   = 32'h0000_0000;
          valid_next = 1'b0;
        end else if (stall) begin
          // Hold everything.
        end else if (state_reg == HALT || past_end) begin
          state_next = HALT;
          instr_next = 32'h0000_0000;
          pc4_next   = 32'h0000_0000;
          valid_next = 1'b0;
        end else begin
          pc_next    = pc_plus4;
          instr_next = imem_instr;
          pc4_next   = pc_plus4;
          valid_next = 1'b1;
          count_next = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;
        end
      end

      default: begin
        state_next = START;
        instr_next = 32'h0000_0000;
        pc4_next   = 32'h0000_0000;
        valid_next = 1'b0;
      end
    endcase

    halted_next = (state_next == HALT);
  end

  // State and datapath registers; reset drops everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= START;
      pc_reg     <= RESET_PC;
      instr_reg  <= 32'h0000_0000;
      pc4_reg    <= 32'h0000_0000;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
      count_reg  <= 16'h0000;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      pc4_reg    <= pc4_next;
      valid_reg  <= valid_next;
      halted_reg <= halted_next;
      count_reg  <= count_next;
    end
  end

  assign imem_addr   = pc_reg;
  assign ifid_instr  = instr_reg;
  assign ifid_pc4    = pc4_reg;
  assign ifid_valid  = valid_reg;
  assign halted      = halted_reg;
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by random
// stall/branch/jump/reset traffic, all checked against a behavioural model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [64];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit          m_started;
  bit          m_halted;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  bit          m_valid;
  int          m_count;

  fetch_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .PROG_WORDS(30)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .ifid_instr   (ifid_instr),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, observed, expected, $time);
  endtask

  task automatic model_reset();
    m_started = 0;
    m_halted  = 0;
    m_pc      = 32'h0;
    m_instr   = 32'h0;
    m_pc4     = 32'h0;
    m_valid   = 0;
    m_count   = 0;
  endtask

  // One clock edge of the sequencer as described in words: start cycle,
  // then redirect > stall > halted/past-end > sequential fetch.
  task automatic model_step(input bit s, input bit b, input logic [31:0] bt,
                            input bit j, input logic [25:0] ji);
    logic [31:0] old_pc4;
    old_pc4 = m_pc4;
    if (!m_started) begin
      m_started = 1;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (b || j) begin
      m_pc = b ? bt : {old_pc4[31:28], ji, 2'b00};
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_halted = 0;
    end else if (s) begin
      // nothing moves
    end else if (m_halted || (m_pc / 4) >= 30) begin
      m_halted = 1;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else begin
      m_instr = mem[m_pc[7:2]];
      m_pc    = m_pc + 4;
      m_pc4   = m_pc;
      m_valid = 1;
      if (m_count < 65535) m_count++;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},   imem_addr,             m_pc);
    check({tag, ".instr"},  ifid_instr,            m_instr);
    check({tag, ".pc4"},    ifid_pc4,              m_pc4);
    check({tag, ".valid"},  {31'b0, ifid_valid},   {31'b0, m_valid});
    check({tag, ".halted"}, {31'b0, halted},       {31'b0, m_halted});
    check({tag, ".count"},  {16'b0, fetch_count},  32'(m_count));
    $display("%s: addr=%08h instr=%08h pc4=%08h v=%0b h=%0b cnt=%0d",
             tag, imem_addr, ifid_instr, ifid_pc4, ifid_valid, halted, fetch_count);
  endtask

  task automatic cycle(input string tag, input bit s, input bit b, input logic [31:0] bt,
                       input bit j, input logic [25:0] ji);
    stall = s; branch_taken = b; branch_target = bt; jump = j; jump_index = ji;
    @(posedge clk);
    model_step(s, b, bt, j, ji);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 32'h0, 0, 26'h0);
  endtask

  // Drop reset between edges and confirm the outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, ".rst_addr"},  imem_addr,            32'h0);
    check({tag, ".rst_valid"}, {31'b0, ifid_valid},  32'h0);
    check({tag, ".rst_count"}, {16'b0, fetch_count}, 32'h0);
    model_reset();
    stall = 0; branch_taken = 0; jump = 0;
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h20080020;
    mem[1] = 32'h20090037;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Start-up: START then RUN
    idle("start");
    check("start.valid", {31'b0, ifid_valid}, 32'h0);
    idle("seq1");
    check("seq1.instr", ifid_instr, 32'h20080020);
    check("seq1.pc4",   ifid_pc4,   32'h4);
    idle("seq2");
    check("seq2.instr", ifid_instr, 32'h20090037);
    check("seq2.pc4",   ifid_pc4,   32'h8);
    check("seq2.count", {16'b0, fetch_count}, 32'd2);

    // Stall at 0x10
    for (int k = 0; k < 16 && m_pc != 32'h10; k++) idle("to10");
    for (int k = 0; k < 3; k++) begin
      cycle("stall", 1, 0, 32'h0, 0, 26'h0);
      check("stall.addr", imem_addr, 32'h10);
    end
    idle("unstall");
    check("unstall.pc4", ifid_pc4, 32'h14);

    // Branch beats stall and jump
    for (int k = 0; k < 16 && m_pc != 32'h24; k++) idle("to24");
    cycle("brall", 1, 1, 32'h48, 1, 26'h3);
    check("brall.addr",  imem_addr,           32'h48);
    check("brall.valid", {31'b0, ifid_valid}, 32'h0);
    idle("postbr");
    check("postbr.pc4",   ifid_pc4,            32'h4C);
    check("postbr.valid", {31'b0, ifid_valid}, 32'h1);

    // Jump arithmetic
    cycle("jump", 0, 0, 32'h0, 1, 26'h0E);
    check("jump.addr", imem_addr, 32'h38);
    idle("postj");
    check("postj.instr", ifid_instr, mem[14]);
    check("postj.pc4",   ifid_pc4,   32'h3C);

    // Run into HALT
    for (int k = 0; k < 64 && !m_halted; k++) idle("tohalt");
    check("halt.flag", {31'b0, halted}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      idle("halted");
      check("halted.addr", imem_addr, 32'h78);
    end
    cycle("haltstall", 1, 0, 32'h0, 0, 26'h0);
    cycle("revive", 0, 1, 32'h38, 0, 26'h0);
    check("revive.halted", {31'b0, halted}, 32'h0);
    check("revive.addr",   imem_addr,       32'h38);

    // Async reset at 0x2C
    cycle("br28", 0, 1, 32'h28, 0, 26'h0);
    idle("at2c");
    check("at2c.addr", imem_addr, 32'h2C);
    async_reset("arst");
    idle("restart");
    idle("reseq1");
    check("reseq1.instr", ifid_instr, 32'h20080020);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      bit s, b, j;
      logic [31:0] bt;
      logic [25:0] ji;
      s  = ($urandom_range(3) == 0);
      b  = ($urandom_range(9) == 0);
      j  = ($urandom_range(11) == 0);
      bt = {24'h0, 6'($urandom_range(63)), 2'b00};
      if ($urandom_range(15) == 0) bt[1:0] = 2'($urandom);
      ji = ($urandom_range(3) == 0) ? 26'($urandom) : 26'($urandom_range(40));
      if ($urandom_range(199) == 0) async_reset("rnd_rst");
      else cycle("rnd", s, b, bt, j, ji);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
